// File: rtl/sort_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sort_pkg
// Description : Shared constants for the 100-element sorter: placement flags,
//               the "no index" marker and the block size.
// Revision    : 1.0 - initial release
// ============================================================================
package sort_pkg;

  // Placement flags produced by the index-finding stage
  localparam logic [1:0] FLAG_INIT   = 2'b00;
  localparam logic [1:0] FLAG_LESS   = 2'b01;
  localparam logic [1:0] FLAG_FIT    = 2'b10;
  localparam logic [1:0] FLAG_LARGER = 2'b11;

  // Global index value meaning "no position found"
  localparam logic [7:0] NO_INDEX    = 8'hFF;

  // Entries held by one sorter block
  localparam int         BLOCK_SIZE  = 10;

endpackage
`default_nettype wire

// File: rtl/sort_insert_shifter.sv
`default_nettype none
// ============================================================================
// Module      : sort_insert_shifter
// Description : Combinational insert network for one sorted bank. Writes the
//               new element at position pos, shifts the entries above it up by
//               one and reports the entry that falls off the top.
// Revision    : 1.0 - initial release
// ============================================================================
module sort_insert_shifter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 10
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] bank_a,
  input  logic [DEPTH-1:0][3:0]       bank_id,
  input  logic [7:0]                  pos,
  input  logic [WIDTH-1:0]            a,
  input  logic [3:0]                  a_id,
  input  logic                        full,
  output logic [DEPTH-1:0][WIDTH-1:0] next_a,
  output logic [DEPTH-1:0][3:0]       next_id,
  output logic [WIDTH-1:0]            drop_a,
  output logic [3:0]                  drop_id,
  output logic                        drop_valid
);

  // Per-entry select: keep below pos, new element at pos, neighbour above pos.
  // Unused entries are all-ones/id 0, so shifting them keeps the fill pattern.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    localparam logic [7:0] c_idx = 8'(i);
    if (i == 0) begin : g_first
      assign next_a[i]  = (pos == c_idx) ? a    : bank_a[i];
      assign next_id[i] = (pos == c_idx) ? a_id : bank_id[i];
    end else begin : g_rest
      assign next_a[i]  = (pos > c_idx)  ? bank_a[i]  :
                          (pos == c_idx) ? a          : bank_a[i-1];
      assign next_id[i] = (pos > c_idx)  ? bank_id[i] :
                          (pos == c_idx) ? a_id       : bank_id[i-1];
    end
  end

  // Inserting just past the top of a full bank drops the incoming element
  assign drop_a     = (pos == 8'(DEPTH)) ? a    : bank_a[DEPTH-1];
  assign drop_id    = (pos == 8'(DEPTH)) ? a_id : bank_id[DEPTH-1];
  assign drop_valid = full;

endmodule
`default_nettype wire

// File: rtl/sort_block_insert.sv
`default_nettype none
// ============================================================================
// Module      : sort_block_insert
// Description : Storage stage for one block of the 100-element sorter. Inserts
//               "fit" elements at the resolved position of its sorted bank and
//               evicts the largest entry toward the next block when full.
//               Optional statistics outputs: define SORT_INSERT_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sort_block_insert
  import sort_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = 0,
  parameter int DEPTH = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_a,
  input  logic [3:0]                  in_a_id,
  input  logic signed [7:0]           in_index,
  input  logic [1:0]                  in_flag,
  output logic [DEPTH-1:0][WIDTH-1:0] array_out,
  output logic [DEPTH-1:0][3:0]       id_out,
  output logic [3:0]                  count,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic [WIDTH-1:0]            ev_a,
  output logic [3:0]                  ev_a_id,
  output logic                        reject
`ifdef SORT_INSERT_STATS_EN
  ,
  output logic [15:0]                 stat_ins,
  output logic [15:0]                 stat_rej,
  output logic [15:0]                 stat_ev
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_EVICT = 1'b1
  } state_t;

  state_t                      r_state, w_state_nxt;
  logic [DEPTH-1:0][WIDTH-1:0] r_bank_a, w_next_a;
  logic [DEPTH-1:0][3:0]       r_bank_id, w_next_id;
  logic [3:0]                  r_count;
  logic [WIDTH-1:0]            r_ev_a, w_drop_a;
  logic [3:0]                  r_ev_id, w_drop_id;
  logic                        r_reject;
  logic                        w_drop_valid;

  // Local position relative to this block's first global slot
  logic signed [7:0] w_p;
  assign w_p = in_index - $signed(8'(BLOCK_SIZE * BLOCK));

  logic w_idle, w_full, w_fit, w_accept, w_ins, w_rej;
  assign w_idle   = (r_state == ST_IDLE);
  assign w_full   = (r_count == 4'(DEPTH));
  assign w_fit    = (in_flag == FLAG_FIT) && !w_p[7] &&
                    (w_p <= $signed({4'b0000, r_count}));
  assign w_accept = in_valid && w_idle;
  assign w_ins    = w_accept && w_fit;
  assign w_rej    = w_accept && !w_fit;

  sort_insert_shifter #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_shifter (
    .bank_a     (r_bank_a),
    .bank_id    (r_bank_id),
    .pos        (w_p),
    .a          (in_a),
    .a_id       (in_a_id),
    .full       (w_full),
    .next_a     (w_next_a),
    .next_id    (w_next_id),
    .drop_a     (w_drop_a),
    .drop_id    (w_drop_id),
    .drop_valid (w_drop_valid)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    ev_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (w_ins && w_full) w_state_nxt = ST_EVICT;
      end
      ST_EVICT: begin
        ev_valid = 1'b1;
        if (ev_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bank, count, eviction register and reject pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank_a  <= '1;
      r_bank_id <= '0;
      r_count   <= 4'd0;
      r_ev_a    <= '0;
      r_ev_id   <= 4'd0;
      r_reject  <= 1'b0;
    end else begin
      r_reject <= w_rej;
      if (w_ins) begin
        r_bank_a  <= w_next_a;
        r_bank_id <= w_next_id;
        if (!w_full) r_count <= r_count + 4'd1;
        if (w_drop_valid) begin
          r_ev_a  <= w_drop_a;
          r_ev_id <= w_drop_id;
        end
      end
    end
  end

  assign array_out = r_bank_a;
  assign id_out    = r_bank_id;
  assign count     = r_count;
  assign ev_a      = r_ev_a;
  assign ev_a_id   = r_ev_id;
  assign reject    = r_reject;

`ifdef SORT_INSERT_STATS_EN
  logic [15:0] r_stat_ins, r_stat_rej, r_stat_ev;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_ins <= 16'd0;
      r_stat_rej <= 16'd0;
      r_stat_ev  <= 16'd0;
    end else begin
      if (w_ins && r_stat_ins != 16'hFFFF) r_stat_ins <= r_stat_ins + 16'd1;
      if (w_rej && r_stat_rej != 16'hFFFF) r_stat_rej <= r_stat_rej + 16'd1;
      if (ev_valid && ev_ready && r_stat_ev != 16'hFFFF)
        r_stat_ev <= r_stat_ev + 16'd1;
    end
  end

  assign stat_ins = r_stat_ins;
  assign stat_rej = r_stat_rej;
  assign stat_ev  = r_stat_ev;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sort_block_insert.sv
`default_nettype none
// ============================================================================
// Module      : tb_sort_block_insert
// Description : Self-checking bench for sort_block_insert (BLOCK=2). A queue
//               model inserts at the local position and pops the tail when it
//               overflows; directed steps followed by random traffic.
//               Statistics checks are active when SORT_INSERT_STATS_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sort_block_insert;
  import sort_pkg::*;

  localparam int WIDTH = 16;
  localparam int BLOCK = 2;
  localparam int DEPTH = 10;
  localparam int BASE  = BLOCK * 10;

  logic                        clk;
  logic                        rst;
  logic                        in_valid;
  logic                        in_ready;
  logic [WIDTH-1:0]            in_a;
  logic [3:0]                  in_a_id;
  logic [7:0]                  in_index;
  logic [1:0]                  in_flag;
  logic [DEPTH-1:0][WIDTH-1:0] array_out;
  logic [DEPTH-1:0][3:0]       id_out;
  logic [3:0]                  count;
  logic                        ev_valid;
  logic                        ev_ready;
  logic [WIDTH-1:0]            ev_a;
  logic [3:0]                  ev_a_id;
  logic                        reject;
`ifdef SORT_INSERT_STATS_EN
  logic [15:0]                 stat_ins, stat_rej, stat_ev;
`endif

  sort_block_insert #(
    .WIDTH (WIDTH),
    .BLOCK (BLOCK),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_a_id   (in_a_id),
    .in_index  (in_index),
    .in_flag   (in_flag),
    .array_out (array_out),
    .id_out    (id_out),
    .count     (count),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_a      (ev_a),
    .ev_a_id   (ev_a_id),
    .reject    (reject)
`ifdef SORT_INSERT_STATS_EN
    ,
    .stat_ins  (stat_ins),
    .stat_rej  (stat_rej),
    .stat_ev   (stat_ev)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [3:0]       id;
  } elem_t;

  // Reference model state
  elem_t            q[$];
  logic             m_evp;
  logic             m_rej;
  logic [WIDTH-1:0] m_eva;
  logic [3:0]       m_evid;
  int               m_ins, m_rejc, m_ev;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [DEPTH-1:0][WIDTH-1:0] ea;
    logic [DEPTH-1:0][3:0]       ei;
    for (int i = 0; i < DEPTH; i++) begin
      ea[i] = (i < q.size()) ? q[i].a  : {WIDTH{1'b1}};
      ei[i] = (i < q.size()) ? q[i].id : 4'd0;
    end
    chk("array_out", 256'(array_out), 256'(ea));
    chk("id_out",    256'(id_out),    256'(ei));
    chk("count",     256'(count),     256'(q.size()));
    chk("reject",    256'(reject),    256'(m_rej));
    chk("ev_valid",  256'(ev_valid),  256'(m_evp));
    chk("in_ready",  256'(in_ready),  256'(!m_evp));
    chk("ev_a",      256'(ev_a),      256'(m_eva));
    chk("ev_a_id",   256'(ev_a_id),   256'(m_evid));
`ifdef SORT_INSERT_STATS_EN
    chk("stat_ins",  256'(stat_ins),  256'(m_ins));
    chk("stat_rej",  256'(stat_rej),  256'(m_rejc));
    chk("stat_ev",   256'(stat_ev),   256'(m_ev));
`endif
  endtask

  // Called at a falling edge; returns at a falling edge after reset releases
  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    ev_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_evp = 1'b0; m_rej = 1'b0; m_eva = '0; m_evid = '0;
    m_ins = 0; m_rejc = 0; m_ev = 0;
    check_all();
  endtask

  // Offer one element for a single cycle; ignored by the model while stalled
  task automatic offer(input logic [WIDTH-1:0] a, input logic [3:0] id,
                       input logic [7:0] idx, input logic [1:0] flag);
    int p;
    in_a = a; in_a_id = id; in_index = idx; in_flag = flag;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    m_rej = 1'b0;
    if (!m_evp) begin
      p = int'($signed(idx)) - BASE;
      if (flag == FLAG_FIT && p >= 0 && p <= q.size()) begin
        q.insert(p, '{a: a, id: id});
        m_ins++;
        if (q.size() > DEPTH) begin
          elem_t e;
          e = q.pop_back();
          m_eva = e.a; m_evid = e.id; m_evp = 1'b1;
        end
      end else begin
        m_rej = 1'b1;
        m_rejc++;
      end
    end
    check_all();
  endtask

  // Hold ev_ready low for 'hold' cycles, then complete the eviction
  task automatic release_ev(input int hold);
    repeat (hold) begin
      @(negedge clk);
      m_rej = 1'b0;
      check_all();
    end
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    m_rej = 1'b0;
    m_evp = 1'b0;
    m_ev++;
    check_all();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; ev_ready = 1'b0;
    in_a = '0; in_a_id = '0; in_index = '0; in_flag = FLAG_INIT;
    repeat (2) @(negedge clk);
    do_reset();

    // Position beyond count is rejected; position 0 is then stored
    offer(16'd99, 4'd3, 8'(BASE + 5), FLAG_FIT);
    chk("tp_reject_pulse", 256'(reject), 256'(1));
    offer(16'd7, 4'd4, 8'(BASE), FLAG_FIT);
    chk("tp_store_e0", 256'(array_out[0]), 256'(16'd7));

    // Two inserts at position 0 keep ascending order
    do_reset();
    offer(16'd50, 4'd1, 8'(BASE), FLAG_FIT);
    offer(16'd30, 4'd2, 8'(BASE), FLAG_FIT);
    chk("tp_a0",  256'(array_out[0]), 256'(16'd30));
    chk("tp_a1",  256'(array_out[1]), 256'(16'd50));
    chk("tp_a2",  256'(array_out[2]), 256'(16'hFFFF));
    chk("tp_id0", 256'(id_out[0]),    256'(4'd2));
    chk("tp_id1", 256'(id_out[1]),    256'(4'd1));

    // Fill with 10..100, then insert 15 at position 1: 100 is evicted
    do_reset();
    for (int k = 1; k <= 10; k++) offer(16'(k * 10), 4'(k), 8'(BASE + k - 1), FLAG_FIT);
    offer(16'd15, 4'd11, 8'(BASE + 1), FLAG_FIT);
    chk("tp_ev100",    256'(ev_a),     256'(16'd100));
    chk("tp_stall",    256'(in_ready), 256'(0));
    chk("tp_bank1_15", 256'(array_out[1]), 256'(16'd15));
    release_ev(1);

    // Insert past the top of a full bank: incoming element is evicted
    offer(16'd200, 4'd12, 8'(BASE + 10), FLAG_FIT);
    chk("tp_ev200", 256'(ev_a), 256'(16'd200));
    offer(16'd5, 4'd5, 8'(BASE), FLAG_FIT);   // ignored while stalled
    release_ev(2);

    // Non-fit flags and the "no index" marker are rejected
    offer(16'd1, 4'd1, 8'(BASE), FLAG_LESS);
    offer(16'd1, 4'd1, 8'(BASE), FLAG_LARGER);
    offer(16'd1, 4'd1, 8'(BASE), FLAG_INIT);
    offer(16'd1, 4'd1, NO_INDEX, FLAG_FIT);

    // ev_ready with nothing pending has no effect
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    m_rej = 1'b0;
    check_all();

    // Reset while an eviction is pending
    offer(16'd3, 4'd3, 8'(BASE), FLAG_FIT);
    chk("tp_evict_before_rst", 256'(ev_valid), 256'(1));
    do_reset();
    chk("tp_rst_ev_a", 256'(ev_a), 256'(0));

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      int r, r2;
      logic [1:0] fl;
      logic [7:0] ix;
      r  = int'($urandom_range(0, 99));
      r2 = int'($urandom_range(0, 9));
      fl = (r < 80) ? FLAG_FIT : 2'($urandom_range(0, 3));
      if (r2 == 0)      ix = NO_INDEX;
      else if (r2 == 1) ix = 8'($urandom_range(0, 60));
      else              ix = 8'(BASE + int'($urandom_range(0, q.size())));
      if (r < 2) begin
        do_reset();
      end else if (m_evp) begin
        if (r < 30) offer(16'($urandom), 4'($urandom), ix, fl);
        else        release_ev(int'($urandom_range(0, 3)));
      end else begin
        offer(16'($urandom), 4'($urandom), ix, fl);
      end
    end
    if (m_evp) release_ev(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
